// File: rtl/combiner_pkg.sv
// Shared types and helpers for the N-channel pulse-train combiner.
// Keeps mode encodings, width arithmetic and saturation in one place for all combiner files.
package combiner_pkg;

    typedef enum logic [1:0] {
        MODE_BYPASS = 2'b00,
        MODE_SUM    = 2'b01,
        MODE_NORM   = 2'b10
    } mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Working width for saturation; any ACC_W up to this value is supported.
    localparam int SAT_W = 64;

    typedef struct packed {
        logic signed [SAT_W-1:0] value;
        logic                    ovf;
    } sat_t;

    function automatic int clog2(input int unsigned v);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((32'd1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    function automatic int flog2(input int unsigned v);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((32'd1 << i) <= v) r = i;
        end
        return r;
    endfunction

    // The reserved encoding 2'b11 runs as a plain sum.
    function automatic mode_e mode_fixup(input logic [1:0] m);
        mode_e r;
        case (m)
            2'b00:   r = MODE_BYPASS;
            2'b10:   r = MODE_NORM;
            default: r = MODE_SUM;
        endcase
        return r;
    endfunction

    // Clamp x into the signed dw-bit range; ovf reports that clamping happened.
    function automatic sat_t saturate(input logic signed [SAT_W-1:0] x, input int unsigned dw);
        logic signed [SAT_W-1:0] one;
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        sat_t r;
        one     = SAT_W'(1);
        hi      = (one <<< (dw - 1)) - one;
        lo      = -hi - one;
        r.value = x;
        r.ovf   = 1'b0;
        if (x > hi) begin
            r.value = hi;
            r.ovf   = 1'b1;
        end else if (x < lo) begin
            r.value = lo;
            r.ovf   = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/combiner_delay_line.sv
// Circular-address delay line: tap returns the word written DEPTH writes ago.
// The address only advances on wr_en, so the delay is counted in accepted samples.
module combiner_delay_line
    import combiner_pkg::*;
#(
    parameter int WIDTH = 18,
    parameter int DEPTH = 100
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] tap
);
    localparam int AW = (DEPTH > 1) ? clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    ptr;

    assign tap = mem[ptr];

    // NOTE: storage deliberately has no reset so it maps onto SRL/RAM; callers never use stale words.
    always_ff @(posedge clk) begin
        if (wr_en) mem[ptr] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (wr_en) begin
            ptr <= (ptr == AW'(DEPTH - 1)) ? '0 : ptr + AW'(1);
        end
    end

endmodule

// File: rtl/combiner_nch.sv
// N-channel pulse-train combiner: sums n_sub consecutive DELAY-sample sub-pulses per channel
// through a recirculating delay line and emits one saturated or normalised combined sub-pulse.
module combiner_nch
    import combiner_pkg::*;
#(
    parameter  int DATA_W    = 16,
    parameter  int N_CH      = 2,
    parameter  int DELAY     = 100,
    parameter  int COMB_FACT = 4,
    localparam int CW        = clog2(COMB_FACT + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   trig,
    input  logic [1:0]             mode,
    input  logic [CW-1:0]          n_sub,
    input  logic [N_CH*DATA_W-1:0] din,
    output logic [N_CH*DATA_W-1:0] dout,
    output logic                   dout_valid,
    output logic                   busy,
    output logic [N_CH-1:0]        ovf
);
    localparam int ACC_W = DATA_W + clog2(COMB_FACT);
    localparam int SW    = clog2(DELAY);
    localparam logic signed [ACC_W-1:0] ACC_ZERO = '0;

    if (DELAY < 2) begin : g_bad_delay
        $error("combiner_nch: DELAY must be at least 2");
    end
    if (COMB_FACT < 1) begin : g_bad_fact
        $error("combiner_nch: COMB_FACT must be at least 1");
    end
    if (ACC_W > SAT_W) begin : g_bad_width
        $error("combiner_nch: accumulator wider than saturation helper");
    end

    state_e        state;
    state_e        state_nxt;
    mode_e         mode_q;
    logic [CW-1:0] n_sub_q;
    logic [CW-1:0] n_fix;
    logic [CW-1:0] shift_q;
    logic [CW-1:0] p_cnt;
    logic [SW-1:0] s_cnt;
    logic          run;
    logic          start;
    logic          s_last;
    logic          p_last;

    logic signed [DATA_W-1:0] din_ch  [N_CH];
    logic signed [ACC_W-1:0]  tap_ch  [N_CH];
    logic signed [ACC_W-1:0]  line_in [N_CH];
    logic        [DATA_W-1:0] sat_val [N_CH];
    logic        [N_CH-1:0]   sat_ovf;

    assign run    = (state == ST_RUN);
    assign busy   = run;
    assign s_last = (s_cnt == SW'(DELAY - 1));
    assign p_last = (p_cnt == n_sub_q - CW'(1));

    always_comb begin
        n_fix = n_sub;
        if (n_sub == '0)                  n_fix = CW'(1);
        else if (n_sub > CW'(COMB_FACT))  n_fix = CW'(COMB_FACT);
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (trig) begin
                    state_nxt = ST_RUN;
                    start     = 1'b1;
                end
            end
            ST_RUN: begin
                if (s_last && p_last) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: clocked state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q  <= MODE_BYPASS;
            n_sub_q <= '0;
            shift_q <= '0;
            s_cnt   <= '0;
            p_cnt   <= '0;
        end else if (start) begin
            mode_q  <= mode_fixup(mode);
            n_sub_q <= n_fix;
            shift_q <= CW'(flog2(32'(n_fix)));
            s_cnt   <= '0;
            p_cnt   <= '0;
        end else if (run) begin
            if (s_last) begin
                s_cnt <= '0;
                p_cnt <= p_last ? '0 : p_cnt + CW'(1);
            end else begin
                s_cnt <= s_cnt + SW'(1);
            end
        end
    end

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        logic signed [ACC_W-1:0] scaled;
        sat_t                    sat_r;

        assign din_ch[c] = din[c*DATA_W +: DATA_W];

        // Pass 0 ignores the tap, which is what makes stale line contents harmless.
        assign line_in[c] = ACC_W'(din_ch[c]) + ((p_cnt == '0) ? ACC_ZERO : tap_ch[c]);

        combiner_delay_line #(
            .WIDTH (ACC_W),
            .DEPTH (DELAY)
        ) u_line (
            .clk   (clk),
            .rst_n (rst_n),
            .wr_en (run),
            .din   (line_in[c]),
            .tap   (tap_ch[c])
        );

        assign scaled     = (mode_q == MODE_NORM) ? (line_in[c] >>> shift_q) : line_in[c];
        assign sat_r      = saturate(SAT_W'(scaled), DATA_W);
        assign sat_val[c] = DATA_W'(sat_r.value);
        assign sat_ovf[c] = sat_r.ovf;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout       <= '0;
            dout_valid <= 1'b0;
            ovf        <= '0;
        end else begin
            dout_valid <= 1'b0;
            if (start) ovf <= '0;
            if (run && mode_q == MODE_BYPASS) begin
                dout       <= din;
                dout_valid <= 1'b1;
            end else if (run && p_last) begin
                dout_valid <= 1'b1;
                ovf        <= ovf | sat_ovf;
                for (int c = 0; c < N_CH; c++) begin
                    dout[c*DATA_W +: DATA_W] <= sat_val[c];
                end
            end
        end
    end

endmodule

// File: tb/tb_combiner_nch.sv
// Self-checking bench for combiner_nch: directed trains plus randomized trains,
// each compared cycle by cycle against a per-train arithmetic reference model.
module tb_combiner_nch;
    localparam int DATA_W    = 16;
    localparam int N_CH      = 2;
    localparam int DELAY     = 4;
    localparam int COMB_FACT = 4;
    localparam int CW        = 3;
    localparam int MAXS      = COMB_FACT * DELAY;
    localparam int SPAN      = MAXS + 3;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   trig;
    logic [1:0]             mode;
    logic [CW-1:0]          n_sub;
    logic [N_CH*DATA_W-1:0] din;
    logic [N_CH*DATA_W-1:0] dout;
    logic                   dout_valid;
    logic                   busy;
    logic [N_CH-1:0]        ovf;

    int total_cnt = 0;
    int bad_cnt   = 0;
    int stim [N_CH][MAXS];

    always #5 clk = ~clk;

    combiner_nch #(
        .DATA_W    (DATA_W),
        .N_CH      (N_CH),
        .DELAY     (DELAY),
        .COMB_FACT (COMB_FACT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .trig       (trig),
        .mode       (mode),
        .n_sub      (n_sub),
        .din        (din),
        .dout       (dout),
        .dout_valid (dout_valid),
        .busy       (busy),
        .ovf        (ovf)
    );

    task automatic check(input string tag, input longint got, input longint exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic longint ch_out(input int c);
        logic signed [DATA_W-1:0] v;
        v = dout[c*DATA_W +: DATA_W];
        return longint'(v);
    endfunction

    function automatic longint clamp16(input longint v, output bit clipped);
        clipped = 1'b0;
        if (v > 32767) begin
            clipped = 1'b1;
            return 32767;
        end
        if (v < -32768) begin
            clipped = 1'b1;
            return -32768;
        end
        return v;
    endfunction

    task automatic drive_random_din();
        for (int c = 0; c < N_CH; c++) din[c*DATA_W +: DATA_W] = 16'($urandom);
    endtask

    task automatic drive_stim(input int i);
        for (int c = 0; c < N_CH; c++) din[c*DATA_W +: DATA_W] = 16'(stim[c][i]);
    endtask

    task automatic fill_const(input int v0, input int v1);
        for (int i = 0; i < MAXS; i++) begin
            stim[0][i] = v0;
            stim[1][i] = v1;
        end
    endtask

    task automatic fill_random();
        logic signed [DATA_W-1:0] r;
        for (int c = 0; c < N_CH; c++) begin
            for (int i = 0; i < MAXS; i++) begin
                r = 16'($urandom);
                stim[c][i] = r;
            end
        end
    endtask

    // Issues one trig from IDLE, feeds stim[][] on the accepted edges and compares every cycle
    // (sampled on negedge) against the expected busy/valid/dout pattern derived from the train rules.
    task automatic run_train(input logic [1:0] md, input int ns, input bit noise);
        int     n_eff;
        int     total;
        int     sh;
        int     emode;
        int     pos;
        longint acc;
        bit     clip;
        bit     exp_v [SPAN];
        longint exp_d [N_CH][SPAN];
        bit     exp_ovf [N_CH];

        n_eff = (ns == 0) ? 1 : ((ns > COMB_FACT) ? COMB_FACT : ns);
        total = n_eff * DELAY;
        sh    = 0;
        while ((1 << (sh + 1)) <= n_eff) sh++;
        emode = (md == 2'b11) ? 1 : int'(md);

        for (int m = 0; m < SPAN; m++) begin
            exp_v[m] = 1'b0;
            for (int c = 0; c < N_CH; c++) exp_d[c][m] = 0;
        end
        for (int c = 0; c < N_CH; c++) exp_ovf[c] = 1'b0;

        if (emode == 0) begin
            for (int i = 0; i < total; i++) begin
                exp_v[i+1] = 1'b1;
                for (int c = 0; c < N_CH; c++) exp_d[c][i+1] = stim[c][i];
            end
        end else begin
            for (int j = 0; j < DELAY; j++) begin
                pos        = total - DELAY + 1 + j;
                exp_v[pos] = 1'b1;
                for (int c = 0; c < N_CH; c++) begin
                    acc = 0;
                    for (int k = 0; k < n_eff; k++) acc += stim[c][k*DELAY + j];
                    if (emode == 2) acc = acc >>> sh;
                    exp_d[c][pos] = clamp16(acc, clip);
                    if (clip) exp_ovf[c] = 1'b1;
                end
            end
        end

        trig  = 1'b1;
        mode  = md;
        n_sub = CW'(ns);
        drive_random_din();
        @(negedge clk);

        for (int m = 0; m < total + 3; m++) begin
            check("busy", busy, (m < total) ? 1 : 0);
            if (m == 0) check("ovf_clear_on_trig", ovf, 0);
            check("valid", dout_valid, exp_v[m]);
            for (int c = 0; c < N_CH; c++) begin
                if (exp_v[m]) check($sformatf("dout_ch%0d_m%0d", c, m), ch_out(c), exp_d[c][m]);
                if (m == total + 1) check($sformatf("dout_hold_ch%0d", c), ch_out(c), exp_d[c][total]);
            end
            if (m == 0) begin
                mode  = 2'($urandom);
                n_sub = CW'($urandom);
            end
            if (m < total) drive_stim(m);
            else           drive_random_din();
            if (noise && m < total - 1) trig = 1'($urandom_range(0, 1));
            else if (noise && m == total - 1) trig = 1'b1;
            else trig = 1'b0;
            @(negedge clk);
        end

        for (int c = 0; c < N_CH; c++) check($sformatf("ovf_ch%0d", c), ovf[c], exp_ovf[c]);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        trig  = 1'b0;
        mode  = 2'b00;
        n_sub = '0;
        din   = '0;

        // Reset held with random activity on the inputs.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            trig = 1'($urandom_range(0, 1));
            drive_random_din();
            check("rst_busy", busy, 0);
            check("rst_valid", dout_valid, 0);
            check("rst_dout", dout, 0);
            check("rst_ovf", ovf, 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        trig  = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            drive_random_din();
            check("idle_busy", busy, 0);
            check("idle_valid", dout_valid, 0);
        end

        // Sum, four sub-pulses.
        fill_const(1000, 0);
        for (int i = 0; i < MAXS; i++) stim[1][i] = (i % 4) + 1;
        run_train(2'b01, 4, 1'b0);

        // Saturation in sum mode, then the same data normalised.
        fill_const(30000, -32768);
        run_train(2'b01, 4, 1'b0);
        run_train(2'b10, 4, 1'b0);

        // n_sub edge cases.
        fill_random();
        run_train(2'b01, 0, 1'b0);
        fill_random();
        run_train(2'b01, 7, 1'b0);
        fill_const(1000, 1000);
        run_train(2'b10, 3, 1'b0);

        // Bypass ramp with spurious trig pulses during RUN and on the final RUN edge.
        for (int i = 0; i < MAXS; i++) begin
            stim[0][i] = i;
            stim[1][i] = 100 + i;
        end
        run_train(2'b00, 2, 1'b1);

        // Abort a sum train in its second pass, then confirm the next train has no residue.
        fill_const(5000, 5000);
        trig  = 1'b1;
        mode  = 2'b01;
        n_sub = 3'd4;
        drive_stim(0);
        @(negedge clk);
        trig = 1'b0;
        repeat (5) @(negedge clk);
        check("abort_busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_valid", dout_valid, 0);
        check("abort_dout", dout, 0);
        check("abort_ovf", ovf, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        fill_const(10, 10);
        run_train(2'b01, 2, 1'b0);

        // Randomized trains, including the reserved mode encoding and out-of-range n_sub.
        for (int t = 0; t < 10; t++) begin
            fill_random();
            run_train(2'($urandom), int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 3)) begin
                drive_random_din();
                @(negedge clk);
                check("gap_busy", busy, 0);
            end
        end

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule

// File: doc/combiner_nch.md
Name: combiner_nch

Overview:
- N-channel, parametrised successor to the single-channel factor-4 pulse-train combiner.
- For each channel, it sums n_sub consecutive sub-pulses of DELAY samples each, using a per-channel recirculating delay line. It emits one combined sub-pulse with a valid strobe.
- Runtime modes: bypass, raw sum (saturated) or normalised sum. A trigger-started sequencer replaces the external integ gating.
- Sits between the ADC capture path and the downstream feedback/readout logic.

Parameters:
- DATA_W, 16, sample width, signed two's complement.
- N_CH, 2, number of channels processed in lock-step.
- DELAY, 100, samples per sub-pulse (delay-line depth, ≥2); 100 ≈ 280 ns at 357 MHz.
- COMB_FACT, 4, maximum sub-pulses per train (≥1).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- trig  in  1  start-of-train strobe, sampled in IDLE only.
- mode  in  2  00 bypass, 01 sum, 10 normalised, 11 treated as 01; latched on trig.
- n_sub  in  CW  sub-pulses to combine, CW=clog2(COMB_FACT+1); latched on trig; 0 is treated as 1, values >COMB_FACT are clamped to COMB_FACT.
- din  in  N_CH*DATA_W  channel c occupies bits [c*DATA_W +: DATA_W].
- dout  out  N_CH*DATA_W  combined output, same packing.
- dout_valid  out  1  dout carries a valid sample.
- busy  out  1  sequencer not in IDLE.
- ovf  out  N_CH  sticky per-channel saturation flag; cleared on accepted trig.

Behaviour:
- Reset (async, rst_n=0):
  - FSM goes to IDLE.
  - dout=0, dout_valid=0, busy=0, ovf=0, counters=0.
  - Delay-line contents are not reset (SRL/RAM friendly); stale contents are never observable.
- Widths:
  - ACC_W = DATA_W + clog2(COMB_FACT).
  - din is sign-extended to ACC_W; delay lines are ACC_W wide.
- FSM states: IDLE, RUN.
  - IDLE → RUN on the edge where trig=1. That edge latches mode, n_sub (after the 0/clamp fix-up) and clears ovf.
  - RUN lasts exactly n_sub*DELAY cycles, tracked by sample counter s (0..DELAY-1) and pass counter p (0..n_sub-1).
  - RUN → IDLE after the edge at which s=DELAY-1 and p=n_sub-1.
  - trig during RUN is ignored. trig on the edge RUN→IDLE is also ignored; the next trig must arrive in IDLE.
- Sample acceptance:
  - din is accepted on every RUN edge, i.e. edges k+1 .. k+n_sub*DELAY after the trig edge k.
  - There is no input handshake.
- Delay line (per channel):
  - line_in = sext(din) + (p==0 ? 0 : tap).
  - tap equals the line_in written exactly DELAY accepted samples earlier.
  - Pass 0 ignores tap, so no clear cycle is needed between trains.
- Output (registered, 1-cycle latency):
  - On edges where p=n_sub-1 in RUN: dout_valid←1 and dout←scale(line_in). Otherwise dout_valid←0 and dout holds its last value.
  - dout_valid is therefore high for exactly DELAY consecutive cycles per train.
- Scaling:
  - sum: clamp line_in to [-2^(DATA_W-1), 2^(DATA_W-1)-1]; if clamped, set ovf[c].
  - normalised: arithmetic shift right by floor(log2(n_sub)), then clamp (sets ovf only for non-power-of-two n_sub).
  - bypass: dout←din on every RUN edge, dout_valid high for all n_sub*DELAY cycles; the delay line is still written but ignored.
- busy = (state==RUN).
- Reset mid-RUN aborts the train immediately. The next train is unaffected because its pass 0 ignores tap.

Decomposition:
- Shared package combiner_pkg:
  - mode encodings MODE_BYPASS/MODE_SUM/MODE_NORM.
  - ceil-log2 constant function.
  - saturate function (ACC_W → DATA_W, returns overflow bit).
- One sub-module combiner_delay_line (width, depth parameters; wr_en, din, tap):
  - Shift register or circular-address RAM.
  - Instantiated N_CH times via generate.

Test Plan (DATA_W=16, N_CH=2, DELAY=4, COMB_FACT=4):
1. Reset: hold rst_n=0 with random din/trig → dout=0, dout_valid=0, busy=0, ovf=0. Release, trig never → stays idle.
2. Sum, n_sub=4: ch0 din=1000 constant; ch1 din=1,2,3,4 repeating → dout_valid high 4 cycles starting 13 cycles after trig edge; ch0=4000 ×4; ch1=4,8,12,16; busy high 16 cycles; ovf=0.
3. Saturation: sum mode, n_sub=4, ch0 din=30000, ch1 din=-32768 → ch0=32767, ch1=-32768, ovf=2'b11. Next trig clears ovf. Same stimulus in normalised mode → 30000 / -32768, ovf=0.
4. n_sub edge cases: n_sub=0 → behaves as 1, dout=din one cycle later, valid 4 cycles. n_sub=7 → clamped to 4, busy 16 cycles. Normalised n_sub=3, din=1000 → 3000>>1=1500.
5. Bypass, n_sub=2: ramp din 0..7 → dout equals din delayed 1 cycle, dout_valid high 8 cycles. trig pulses during RUN have no effect.
6. rst_n pulsed low mid pass 2 of a sum train with din=5000, then new sum train n_sub=2 with din=10 → dout=20 ×4, no residue from the aborted train.
